// File: rtl/mc_pkg.sv
// Shared types and encodings for the multicycle MIPS controller.
// Optional feature macro: MC_BNE_EN (adds the BNEEX state for opcode 000101).
package mc_pkg;

  typedef enum logic [3:0] {
    FETCH   = 4'd0,
    DECODE  = 4'd1,
    MEMADR  = 4'd2,
    MEMRD   = 4'd3,
    MEMWB   = 4'd4,
    MEMWR   = 4'd5,
    RTYPEEX = 4'd6,
    RTYPEWB = 4'd7,
    BEQEX   = 4'd8,
    ADDIEX  = 4'd9,
    ADDIWB  = 4'd10,
    JEX     = 4'd11
`ifdef MC_BNE_EN
    ,
    BNEEX   = 4'd12
`endif
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_SLT = 6'b101010;
  localparam logic [5:0] FN_SLL = 6'b000000;
  localparam logic [5:0] FN_NOR = 6'b100111;

  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_SUB = 4'b1010;
  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_SLT = 4'b1011;
  localparam logic [3:0] ALU_SLL = 4'b0100;
  localparam logic [3:0] ALU_NOR = 4'b0111;

  typedef struct packed {
    logic [3:0] alucontrol;
    logic       alusrca;
    logic [1:0] alusrcb;
    logic [1:0] pcsrc;
    logic       pcen;
    logic       irwrite;
    logic       memwrite;
    logic       regwrite;
    logic       iord;
    logic       regdst;
    logic       memtoreg;
  } ctrl_t;

  localparam ctrl_t CTRL_IDLE = '{
    alucontrol: ALU_ADD, alusrca: 1'b0, alusrcb: 2'b00, pcsrc: 2'b00,
    pcen: 1'b0, irwrite: 1'b0, memwrite: 1'b0, regwrite: 1'b0,
    iord: 1'b0, regdst: 1'b0, memtoreg: 1'b0
  };

  // Suppress every architectural write strobe, leaving the mux selects intact.
  function automatic ctrl_t strobes_off(input ctrl_t c);
    ctrl_t r;
    r          = c;
    r.pcen     = 1'b0;
    r.irwrite  = 1'b0;
    r.memwrite = 1'b0;
    r.regwrite = 1'b0;
    return r;
  endfunction

endpackage

// File: rtl/mc_controller_aludec.sv
// Combinational R-type funct field to ALU control decode.
module aludec
  import mc_pkg::*;
(
  input  logic [5:0] funct,
  output logic [3:0] alucontrol
);

  // Funct decode; unknown functs fall back to add.
  always_comb begin
    alucontrol = ALU_ADD;
    case (funct)
      FN_ADD:  alucontrol = ALU_ADD;
      FN_SUB:  alucontrol = ALU_SUB;
      FN_AND:  alucontrol = ALU_AND;
      FN_OR:   alucontrol = ALU_OR;
      FN_SLT:  alucontrol = ALU_SLT;
      FN_SLL:  alucontrol = ALU_SLL;
      FN_NOR:  alucontrol = ALU_NOR;
      default: alucontrol = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/mc_controller.sv
// Moore-style control FSM for a multicycle MIPS datapath.
// Optional feature macro: MC_BNE_EN (bne support via BNEEX state).
module mc_controller
  import mc_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] op,
  input  logic [5:0] funct,
  input  logic       zero,
  output logic [3:0] alucontrol,
  output logic       alusrca,
  output logic [1:0] alusrcb,
  output logic [1:0] pcsrc,
  output logic       pcen,
  output logic       irwrite,
  output logic       memwrite,
  output logic       regwrite,
  output logic       iord,
  output logic       regdst,
  output logic       memtoreg
);

  state_t     state_r;
  state_t     next_state_s;
  logic [3:0] funct_alu_s;
  ctrl_t      ctrl_s;
  ctrl_t      ctrl_out_s;

  aludec u_aludec (
    .funct      (funct),
    .alucontrol (funct_alu_s)
  );

  // State register with synchronous reset back to FETCH.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= FETCH;
    end else begin
      state_r <= next_state_s;
    end
  end

  // Next-state and per-state control decode.
  always_comb begin
    next_state_s = FETCH;
    ctrl_s       = CTRL_IDLE;
    case (state_r)
      FETCH: begin
        next_state_s   = DECODE;
        ctrl_s.alusrcb = 2'b01;
        ctrl_s.irwrite = 1'b1;
        ctrl_s.pcen    = 1'b1;
      end
      DECODE: begin
        ctrl_s.alusrcb = 2'b11;
        case (op)
          OP_LW, OP_SW: next_state_s = MEMADR;
          OP_RTYPE:     next_state_s = RTYPEEX;
          OP_BEQ:       next_state_s = BEQEX;
          OP_ADDI:      next_state_s = ADDIEX;
          OP_J:         next_state_s = JEX;
`ifdef MC_BNE_EN
          OP_BNE:       next_state_s = BNEEX;
`endif
          default:      next_state_s = FETCH;
        endcase
      end
      MEMADR: begin
        ctrl_s.alusrca = 1'b1;
        ctrl_s.alusrcb = 2'b10;
        if (op == OP_SW) begin
          next_state_s = MEMWR;
        end else begin
          next_state_s = MEMRD;
        end
      end
      MEMRD: begin
        next_state_s = MEMWB;
        ctrl_s.iord  = 1'b1;
      end
      MEMWB: begin
        next_state_s    = FETCH;
        ctrl_s.memtoreg = 1'b1;
        ctrl_s.regwrite = 1'b1;
      end
      MEMWR: begin
        next_state_s    = FETCH;
        ctrl_s.iord     = 1'b1;
        ctrl_s.memwrite = 1'b1;
      end
      RTYPEEX: begin
        next_state_s      = RTYPEWB;
        ctrl_s.alusrca    = 1'b1;
        ctrl_s.alucontrol = funct_alu_s;
      end
      RTYPEWB: begin
        next_state_s    = FETCH;
        ctrl_s.regdst   = 1'b1;
        ctrl_s.regwrite = 1'b1;
      end
      BEQEX: begin
        next_state_s      = FETCH;
        ctrl_s.alusrca    = 1'b1;
        ctrl_s.alucontrol = ALU_SUB;
        ctrl_s.pcsrc      = 2'b01;
        ctrl_s.pcen       = zero;
      end
`ifdef MC_BNE_EN
      BNEEX: begin
        next_state_s      = FETCH;
        ctrl_s.alusrca    = 1'b1;
        ctrl_s.alucontrol = ALU_SUB;
        ctrl_s.pcsrc      = 2'b01;
        ctrl_s.pcen       = ~zero;
      end
`endif
      ADDIEX: begin
        next_state_s   = ADDIWB;
        ctrl_s.alusrca = 1'b1;
        ctrl_s.alusrcb = 2'b10;
      end
      ADDIWB: begin
        next_state_s    = FETCH;
        ctrl_s.regwrite = 1'b1;
      end
      JEX: begin
        next_state_s = FETCH;
        ctrl_s.pcsrc = 2'b10;
        ctrl_s.pcen  = 1'b1;
      end
      default: begin
        next_state_s = FETCH;
        ctrl_s       = CTRL_IDLE;
      end
    endcase
  end

  // Reset kills write strobes in the same cycle it is seen.
  always_comb begin
    ctrl_out_s = ctrl_s;
    if (reset) begin
      ctrl_out_s = strobes_off(ctrl_s);
    end else begin
      ctrl_out_s = ctrl_s;
    end
  end

  assign alucontrol = ctrl_out_s.alucontrol;
  assign alusrca    = ctrl_out_s.alusrca;
  assign alusrcb    = ctrl_out_s.alusrcb;
  assign pcsrc      = ctrl_out_s.pcsrc;
  assign pcen       = ctrl_out_s.pcen;
  assign irwrite    = ctrl_out_s.irwrite;
  assign memwrite   = ctrl_out_s.memwrite;
  assign regwrite   = ctrl_out_s.regwrite;
  assign iord       = ctrl_out_s.iord;
  assign regdst     = ctrl_out_s.regdst;
  assign memtoreg   = ctrl_out_s.memtoreg;

endmodule

// File: tb/tb_mc_controller.sv
// Scoreboard bench for mc_controller: directed per-cycle vectors, decoupled monitor.
module tb_mc_controller;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [5:0] op = 6'b111111;
  logic [5:0] funct = 6'b111111;
  logic       zero = 1'b0;
  logic [3:0] alucontrol;
  logic       alusrca;
  logic [1:0] alusrcb;
  logic [1:0] pcsrc;
  logic       pcen, irwrite, memwrite, regwrite, iord, regdst, memtoreg;

  int checks = 0;
  int errors = 0;

  logic [15:0] q_vec[$];
  string       q_name[$];
  logic [15:0] obs;

  mc_controller dut (
    .clk(clk), .reset(reset), .op(op), .funct(funct), .zero(zero),
    .alucontrol(alucontrol), .alusrca(alusrca), .alusrcb(alusrcb), .pcsrc(pcsrc),
    .pcen(pcen), .irwrite(irwrite), .memwrite(memwrite), .regwrite(regwrite),
    .iord(iord), .regdst(regdst), .memtoreg(memtoreg)
  );

  always #5 clk = ~clk;

  assign obs = {alucontrol, alusrca, alusrcb, pcsrc,
                pcen, irwrite, memwrite, regwrite, iord, regdst, memtoreg};

  // Vector layout: {alu[3:0], srca, srcb[1:0], pcsrc[1:0], pcen, irw, memw, regw, iord, regdst, memtoreg}
  localparam logic [15:0] V_F    = {4'b0010, 1'b0, 2'b01, 2'b00, 7'b1100000};
  localparam logic [15:0] V_FR   = {4'b0010, 1'b0, 2'b01, 2'b00, 7'b0000000};
  localparam logic [15:0] V_D    = {4'b0010, 1'b0, 2'b11, 2'b00, 7'b0000000};
  localparam logic [15:0] V_MA   = {4'b0010, 1'b1, 2'b10, 2'b00, 7'b0000000};
  localparam logic [15:0] V_MR   = {4'b0010, 1'b0, 2'b00, 2'b00, 7'b0000100};
  localparam logic [15:0] V_MWB  = {4'b0010, 1'b0, 2'b00, 2'b00, 7'b0001001};
  localparam logic [15:0] V_MWBR = {4'b0010, 1'b0, 2'b00, 2'b00, 7'b0000001};
  localparam logic [15:0] V_MW   = {4'b0010, 1'b0, 2'b00, 2'b00, 7'b0010100};
  localparam logic [15:0] V_MWR  = {4'b0010, 1'b0, 2'b00, 2'b00, 7'b0000100};
  localparam logic [15:0] V_RWB  = {4'b0010, 1'b0, 2'b00, 2'b00, 7'b0001010};
  localparam logic [15:0] V_AWB  = {4'b0010, 1'b0, 2'b00, 2'b00, 7'b0001000};
  localparam logic [15:0] V_J    = {4'b0010, 1'b0, 2'b00, 2'b10, 7'b1000000};
  localparam logic [15:0] V_BQ1  = {4'b1010, 1'b1, 2'b00, 2'b01, 7'b1000000};
  localparam logic [15:0] V_BQ0  = {4'b1010, 1'b1, 2'b00, 2'b01, 7'b0000000};

  localparam logic [5:0] XX = 6'b111111;

  function automatic logic [15:0] v_rx(input logic [3:0] alu);
    return {alu, 1'b1, 2'b00, 2'b00, 7'b0000000};
  endfunction

  // Drive one cycle of inputs and record the outputs that cycle must show.
  task automatic step(input logic rst, input logic [5:0] o, input logic [5:0] f,
                      input logic z, input logic [15:0] e, input string nm);
    @(posedge clk);
    #1;
    reset = rst;
    op    = o;
    funct = f;
    zero  = z;
    q_vec.push_back(e);
    q_name.push_back(nm);
  endtask

  // Monitor: compare the DUT outputs against the oldest expectation each cycle.
  always @(negedge clk) begin
    logic [15:0] e;
    string       nm;
    if (q_vec.size() > 0) begin
      e  = q_vec.pop_front();
      nm = q_name.pop_front();
      checks++;
      if (obs !== e) begin
        errors++;
        $display("FAIL %s: got %h expected %h", nm, obs, e);
      end
    end
  end

  logic [5:0] fn_t [8] = '{6'b100000, 6'b100010, 6'b100100, 6'b100101,
                           6'b101010, 6'b000000, 6'b100111, 6'b111111};
  logic [3:0] al_t [8] = '{4'b0010, 4'b1010, 4'b0000, 4'b0001,
                           4'b1011, 4'b0100, 4'b0111, 4'b0010};

  initial begin
    // reset held, then released: first cycle afterwards is FETCH
    step(1'b1, XX, XX, 1'b0, V_FR, "reset_fetch");
    step(1'b0, XX, XX, 1'b0, V_F,  "fetch_after_reset");
    // lw: 5 cycles, op garbage outside DECODE/MEMADR
    step(1'b0, 6'b100011, XX, 1'b0, V_D,   "lw_decode");
    step(1'b0, 6'b100011, XX, 1'b0, V_MA,  "lw_memadr");
    step(1'b0, XX,        XX, 1'b0, V_MR,  "lw_memrd");
    step(1'b0, XX,        XX, 1'b0, V_MWB, "lw_memwb");
    step(1'b0, XX,        XX, 1'b0, V_F,   "lw_back_fetch");
    // sw: 4 cycles
    step(1'b0, 6'b101011, XX, 1'b0, V_D,  "sw_decode");
    step(1'b0, 6'b101011, XX, 1'b0, V_MA, "sw_memadr");
    step(1'b0, XX,        XX, 1'b0, V_MW, "sw_memwr");
    step(1'b0, XX,        XX, 1'b0, V_F,  "sw_fetch");
    // R-type funct decode table, including unknown funct
    for (int i = 0; i < 8; i++) begin
      step(1'b0, 6'b000000, XX,      1'b0, V_D,           "rt_decode");
      step(1'b0, XX,        fn_t[i], 1'b0, v_rx(al_t[i]), "rt_ex_alucontrol");
      step(1'b0, XX,        XX,      1'b0, V_RWB,         "rt_wb");
      step(1'b0, XX,        XX,      1'b0, V_F,           "rt_fetch");
    end
    // addi
    step(1'b0, 6'b001000, XX, 1'b0, V_D,   "addi_decode");
    step(1'b0, XX,        XX, 1'b0, V_MA,  "addi_ex");
    step(1'b0, XX,        XX, 1'b0, V_AWB, "addi_wb");
    step(1'b0, XX,        XX, 1'b0, V_F,   "addi_fetch");
    // beq taken and not taken
    step(1'b0, 6'b000100, XX, 1'b0, V_D,   "beq1_decode");
    step(1'b0, XX,        XX, 1'b1, V_BQ1, "beq_zero1");
    step(1'b0, XX,        XX, 1'b0, V_F,   "beq1_fetch");
    step(1'b0, 6'b000100, XX, 1'b0, V_D,   "beq0_decode");
    step(1'b0, XX,        XX, 1'b0, V_BQ0, "beq_zero0");
    step(1'b0, XX,        XX, 1'b0, V_F,   "beq0_fetch");
    // j
    step(1'b0, 6'b000010, XX, 1'b0, V_D, "j_decode");
    step(1'b0, XX,        XX, 1'b0, V_J, "j_ex");
    step(1'b0, XX,        XX, 1'b0, V_F, "j_fetch");
    // illegal opcode: 2 cycles, no strobes
    step(1'b0, 6'b111111, XX, 1'b0, V_D, "ill_decode");
    step(1'b0, XX,        XX, 1'b0, V_F, "ill_fetch");
    // bne
    step(1'b0, 6'b000101, XX, 1'b0, V_D, "bne_decode");
`ifdef MC_BNE_EN
    step(1'b0, XX,        XX, 1'b0, V_BQ1, "bne_zero0");
    step(1'b0, XX,        XX, 1'b0, V_F,   "bne0_fetch");
    step(1'b0, 6'b000101, XX, 1'b0, V_D,   "bne1_decode");
    step(1'b0, XX,        XX, 1'b1, V_BQ0, "bne_zero1");
    step(1'b0, XX,        XX, 1'b0, V_F,   "bne1_fetch");
`else
    step(1'b0, XX,        XX, 1'b0, V_F, "bne_illegal_fetch");
`endif
    // reset during sw MEMWR
    step(1'b0, 6'b101011, XX, 1'b0, V_D,   "swr_decode");
    step(1'b0, 6'b101011, XX, 1'b0, V_MA,  "swr_memadr");
    step(1'b1, XX,        XX, 1'b0, V_MWR, "swr_memwr_reset");
    step(1'b1, XX,        XX, 1'b0, V_FR,  "swr_fetch_in_reset");
    step(1'b0, XX,        XX, 1'b0, V_F,   "swr_fetch_released");
    // reset during lw MEMWB abandons the register write
    step(1'b0, 6'b100011, XX, 1'b0, V_D,    "lwr_decode");
    step(1'b0, 6'b100011, XX, 1'b0, V_MA,   "lwr_memadr");
    step(1'b0, XX,        XX, 1'b0, V_MR,   "lwr_memrd");
    step(1'b1, XX,        XX, 1'b0, V_MWBR, "lwr_memwb_reset");
    step(1'b0, XX,        XX, 1'b0, V_F,    "lwr_fetch");
    step(1'b0, XX,        XX, 1'b0, V_D,    "final_decode");

    for (int i = 0; i < 4 && q_vec.size() > 0; i++) @(negedge clk);
    #1;
    checks++;
    if (q_vec.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d pending expected 0", q_vec.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mc_controller.md
MC_CONTROLLER -- requirements
Module: mc_controller

Interface
REQ-001 clk  input  1  rising-edge clock; single clock domain.
REQ-002 reset  input  1  synchronous, active-high reset.
REQ-003 op  input  6  instruction opcode (instr[31:26]), sampled from the datapath instruction register.
REQ-004 funct  input  6  R-type function field (instr[5:0]).
REQ-005 zero  input  1  ALU zero flag of the current cycle.
REQ-006 alucontrol  output  4  ALU operation: bit3 inverts b and sets carry-in, bits[2:0] select the operation.
REQ-007 alusrca  output  1  0 = PC, 1 = register A.
REQ-008 alusrcb  output  2  00 = register B, 01 = constant 4, 10 = signimm, 11 = signimm<<2.
REQ-009 pcsrc  output  2  00 = ALU result, 01 = ALUOut, 10 = jump target.
REQ-010 pcen, irwrite, memwrite, regwrite, iord, regdst, memtoreg  output  1 each  standard multicycle datapath controls.

Function
REQ-011 The block SHALL be a Moore FSM with states FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, RTYPEEX, RTYPEWB, BEQEX, ADDIEX, ADDIWB and JEX; the state register updates on the rising edge of clk.
REQ-012 Transitions: FETCH->DECODE. DECODE->MEMADR (lw 100011, sw 101011), RTYPEEX (000000), BEQEX (000100), ADDIEX (001000), JEX (000010); any other opcode returns to FETCH (no-op).
REQ-013 Further transitions: MEMADR->MEMRD (lw) or MEMWR (sw); MEMRD->MEMWB; RTYPEEX->RTYPEWB; ADDIEX->ADDIWB; MEMWB, MEMWR, RTYPEWB, BEQEX, ADDIWB and JEX each return to FETCH.
REQ-014 Outputs not listed for a state SHALL be 0, and alucontrol SHALL be 0010 unless stated otherwise.
- FETCH: alusrcb=01, irwrite=1, pcen=1
- DECODE: alusrcb=11
- MEMADR and ADDIEX: alusrca=1, alusrcb=10
- MEMRD: iord=1
- MEMWB: memtoreg=1, regwrite=1
- MEMWR: iord=1, memwrite=1
- RTYPEEX: alusrca=1, alucontrol=decoded funct
- RTYPEWB: regdst=1, regwrite=1
- ADDIWB: regwrite=1
- BEQEX: alusrca=1, alucontrol=1010, pcsrc=01, pcen=zero
- JEX: pcsrc=10, pcen=1
REQ-015 The funct decode SHALL map:
- add 100000 -> 0010
- sub 100010 -> 1010
- and 100100 -> 0000
- or 100101 -> 0001
- slt 101010 -> 1011
- sll 000000 -> 0100
- nor 100111 -> 0111
- any other funct -> 0010
REQ-016 Instruction latencies in cycles SHALL be: lw 5, sw 4, R-type 4, addi 4, beq 3, j 3, illegal opcode 2.
REQ-017 op and funct SHALL be consumed only in DECODE, MEMADR and RTYPEEX; changes in other states SHALL have no effect.

Reset
REQ-018 While reset=1, the next state SHALL be FETCH, and pcen, irwrite, memwrite and regwrite SHALL be forced to 0 in the same cycle.
REQ-019 Reset asserted mid-instruction SHALL abandon the instruction with no further write strobes; the first cycle after reset is released SHALL be FETCH.

Configuration
REQ-020 With macro MC_BNE_EN defined, opcode 000101 SHALL go DECODE->BNEEX, which drives BEQEX outputs except pcen=~zero, then returns to FETCH (3 cycles).
REQ-021 Without MC_BNE_EN, opcode 000101 SHALL be treated as an illegal opcode (REQ-012), and the BNEEX state SHALL not exist.

Structure
REQ-022 The package mc_pkg SHALL hold the state enum, the opcode and funct constants, and the alucontrol encodings; the datapath SHALL import it.
REQ-023 The funct-to-alucontrol decode SHALL be the sub-module aludec (combinational, inputs funct, output alucontrol), instantiated once.

Verification
REQ-024 Release reset, apply op=100011 -> states FETCH, DECODE, MEMADR, MEMRD, MEMWB; regwrite=1 and memtoreg=1 only in cycle 5; back in FETCH in cycle 6.
REQ-025 R-type funct=101010 -> alucontrol=1011 in RTYPEEX; regdst=1 and regwrite=1 in RTYPEWB; for funct=111111, alucontrol=0010.
REQ-026 beq with zero=1 in BEQEX -> pcen=1 and pcsrc=01; repeat with zero=0 -> pcen=0; FETCH follows in both cases.
REQ-027 op=111111 -> FETCH, DECODE, FETCH with no regwrite or memwrite strobes; with MC_BNE_EN and op=000101, zero=0 -> pcen=1 in BNEEX.
REQ-028 Assert reset during MEMWR of sw -> memwrite=0 in that cycle; next state FETCH; the FETCH strobes appear only after reset is released.
